mem_controller_mp: RTL and testbench

MEM_CONTROLLER_MP -- requirements
Module: mem_controller_mp

---
 rtl/mem_controller_mp.sv | 219 +++++++++++++++++++++
 tb/tb_mem_controller_mp.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_controller_mp.sv
// Multi-port SDRAM front end: round-robin arbitration, lane steering and fixed-latency read return.
// Build with MEM_CTRL_AUTO_REFRESH_EN defined to add an internal periodic refresh timer.
module mem_controller_mp #(
    parameter int FREQ           = 54_000_000,
    parameter int CHANNELS       = 2,
    parameter int ADDR_WIDTH     = 23,
    parameter int LATENCY        = 4,
    parameter int REFRESH_CYCLES = 810
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [CHANNELS-1:0]            req_read,
    input  logic [CHANNELS-1:0]            req_write,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] req_addr,
    input  logic [CHANNELS*2-1:0]          req_size,
    input  logic [CHANNELS*32-1:0]         req_din,
    output logic [CHANNELS-1:0]            req_ack,
    output logic [CHANNELS-1:0]            rd_valid,
    output logic [31:0]                    rd_data,
    input  logic                           refresh,
    output logic                           busy,
    output logic                           fail,
    output logic [ADDR_WIDTH-3:0]          sdram_addr,
    output logic                           sdram_rd,
    output logic                           sdram_wr,
    output logic                           sdram_refresh,
    output logic [31:0]                    sdram_din32,
    output logic [3:0]                     sdram_wdm,
    input  logic [31:0]                    sdram_dout32,
    input  logic                           sdram_busy,
    input  logic                           sdram_data_ready
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [2:0] LAT = 3'(LATENCY);

    localparam logic [1:0] S_INIT  = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    logic [1:0]            r_state;
    logic [2:0]            r_cnt;
    logic [CH_W-1:0]       r_grant;
    logic [CH_W-1:0]       r_last;
    logic                  r_op_wr;
    logic                  r_op_ref;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_size;
    logic [31:0]           r_din;
    logic                  r_ref_pend;
    logic [CHANNELS-1:0]   r_rd_valid;
    logic [31:0]           r_rd_data;
    logic                  r_fail;

    logic                  w_found;
    logic [CH_W-1:0]       w_sel;
    logic [CH_W-1:0]       w_pick;
    int                    w_idx;
    logic                  w_req_any;
    logic                  w_ref_tick;
    logic                  w_ref_want;
    logic                  w_start;
    logic [31:0]           w_rd_lane;
    logic [31:0]           w_din32;
    logic [3:0]            w_wdm;
    logic [CHANNELS-1:0]   w_ack;

    // Round-robin: first requester after the last granted channel, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = 0;
        w_pick  = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            w_idx  = (int'(r_last) + k) % CHANNELS;
            w_pick = w_idx[CH_W-1:0];
            if (!w_found && (req_read[w_pick] || req_write[w_pick])) begin
                w_found = 1'b1;
                w_sel   = w_pick;
            end
        end
    end

    assign w_req_any  = |(req_read | req_write);
    assign w_ref_want = r_ref_pend | refresh | w_ref_tick;
    assign w_start    = (r_state == S_IDLE) && !sdram_busy && (w_ref_want || w_req_any);

`ifdef MEM_CTRL_AUTO_REFRESH_EN
    localparam int RT_W = $clog2(REFRESH_CYCLES + 1);
    logic [RT_W-1:0] r_ref_timer;

    assign w_ref_tick = (r_ref_timer == RT_W'(REFRESH_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ref_timer <= '0;
        end else if (w_ref_tick || (w_start && w_ref_want)) begin
            r_ref_timer <= '0;
        end else begin
            r_ref_timer <= r_ref_timer + 1'b1;
        end
    end
`else
    assign w_ref_tick = 1'b0;
`endif

    always_comb begin
        w_rd_lane = sdram_dout32;
        case (r_size)
            2'b00:   w_rd_lane = {24'h0, sdram_dout32[{r_addr[1:0], 3'b000} +: 8]};
            2'b01:   w_rd_lane = {16'h0, r_addr[1] ? sdram_dout32[31:16] : sdram_dout32[15:0]};
            default: w_rd_lane = sdram_dout32;
        endcase
    end

    always_comb begin
        w_din32 = r_din;
        w_wdm   = 4'b0000;
        case (r_size)
            2'b00: begin
                w_din32 = {4{r_din[7:0]}};
                w_wdm   = ~(4'b0001 << r_addr[1:0]);
            end
            2'b01: begin
                w_din32 = {2{r_din[15:0]}};
                w_wdm   = r_addr[1] ? 4'b0011 : 4'b1100;
            end
            default: begin
                w_din32 = r_din;
                w_wdm   = 4'b0000;
            end
        endcase
        if (!r_op_wr) w_wdm = 4'b0000;
    end

    always_comb begin
        w_ack = '0;
        if (r_state == S_ISSUE && !r_op_ref) w_ack[r_grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ref_pend <= 1'b0;
        end else if (w_start && w_ref_want) begin
            r_ref_pend <= 1'b0;
        end else if (refresh || w_ref_tick) begin
            r_ref_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_INIT;
            r_cnt      <= '0;
            r_grant    <= '0;
            r_last     <= CH_W'(CHANNELS - 1);
            r_op_wr    <= 1'b0;
            r_op_ref   <= 1'b0;
            r_addr     <= '0;
            r_size     <= '0;
            r_din      <= '0;
            r_rd_valid <= '0;
            r_rd_data  <= '0;
            r_fail     <= 1'b0;
        end else begin
            r_rd_valid <= '0;
            case (r_state)
                S_INIT: if (!sdram_busy) r_state <= S_IDLE;
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_ISSUE;
                        if (w_ref_want) begin
                            r_op_ref <= 1'b1;
                            r_op_wr  <= 1'b0;
                        end else begin
                            r_op_ref <= 1'b0;
                            r_grant  <= w_sel;
                            r_last   <= w_sel;
                            r_op_wr  <= req_write[w_sel];
                            r_addr   <= req_addr[w_sel*ADDR_WIDTH +: ADDR_WIDTH];
                            r_size   <= req_size[w_sel*2 +: 2];
                            r_din    <= req_din[w_sel*32 +: 32];
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                    r_cnt   <= 3'd1;
                end
                S_WAIT: begin
                    if (r_cnt == LAT) begin
                        r_state <= S_IDLE;
                        if (!r_op_wr && !r_op_ref) begin
                            r_rd_data           <= w_rd_lane;
                            r_rd_valid[r_grant] <= 1'b1;
                            if (!sdram_data_ready) r_fail <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign fail          = r_fail;
    assign req_ack       = w_ack;
    assign rd_valid      = r_rd_valid;
    assign rd_data       = r_rd_data;
    assign sdram_addr    = r_addr[ADDR_WIDTH-1:2];
    assign sdram_rd      = (r_state == S_ISSUE) && !r_op_ref && !r_op_wr;
    assign sdram_wr      = (r_state == S_ISSUE) && !r_op_ref && r_op_wr;
    assign sdram_refresh = (r_state == S_ISSUE) && r_op_ref;
    assign sdram_din32   = w_din32;
    assign sdram_wdm     = w_wdm;

endmodule

// File: tb/tb_mem_controller_mp.sv
// Bench for mem_controller_mp: vector table of single transfers plus arbitration, refresh, fail and abort sequences.
module tb_mem_controller_mp;
    localparam int CH  = 2;
    localparam int AW  = 23;
    localparam int LAT = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic [CH-1:0]     req_read, req_write, req_ack, rd_valid;
    logic [CH*AW-1:0]  req_addr;
    logic [CH*2-1:0]   req_size;
    logic [CH*32-1:0]  req_din;
    logic [31:0]       rd_data, sdram_din32, sdram_dout32;
    logic              refresh, busy, fail, sdram_rd, sdram_wr, sdram_refresh;
    logic              sdram_busy, sdram_data_ready;
    logic [AW-3:0]     sdram_addr;
    logic [3:0]        sdram_wdm;

    always #5 clk = ~clk;

    mem_controller_mp #(.CHANNELS(CH), .ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk(clk), .resetn(resetn),
        .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
        .req_size(req_size), .req_din(req_din), .req_ack(req_ack),
        .rd_valid(rd_valid), .rd_data(rd_data), .refresh(refresh),
        .busy(busy), .fail(fail), .sdram_addr(sdram_addr),
        .sdram_rd(sdram_rd), .sdram_wr(sdram_wr), .sdram_refresh(sdram_refresh),
        .sdram_din32(sdram_din32), .sdram_wdm(sdram_wdm), .sdram_dout32(sdram_dout32),
        .sdram_busy(sdram_busy), .sdram_data_ready(sdram_data_ready)
    );

    typedef struct {
        logic        wr;
        logic        both;
        int          ch;
        logic [22:0] addr;
        logic [1:0]  size;
        logic [31:0] din;
        logic [31:0] dout;
        logic [20:0] exp_addr;
        logic [31:0] exp_din;
        logic [3:0]  exp_wdm;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs[9];
    vec_t        fv;
    int          checks = 0;
    int          errors = 0;
    int          n_rdv  = 0;
    int          exp_rdv = 0;
    logic [31:0] sb_q[$];

    always @(negedge clk) if (|rd_valid) n_rdv++;

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_req();
        req_read  = '0;
        req_write = '0;
    endtask

    task automatic set_req(input int ch, input logic wr, input logic rd, input logic [22:0] addr,
                           input logic [1:0] size, input logic [31:0] din);
        req_write[ch]          = wr;
        req_read[ch]           = rd;
        req_addr[ch*AW +: AW]  = addr;
        req_size[ch*2 +: 2]    = size;
        req_din[ch*32 +: 32]   = din;
    endtask

    task automatic wait_cmd(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sdram_rd || sdram_wr || sdram_refresh) && n < 40);
        if (!(sdram_rd || sdram_wr || sdram_refresh)) begin
            checks++;
            errors++;
            $display("FAIL cmd_timeout: no command after %0d cycles", n);
        end
    endtask

    task automatic wait_rdv(input int ch);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rd_valid == '0 && n < 20);
        if (rd_valid == '0) begin
            checks++;
            errors++;
            $display("FAIL rdv_timeout: no rd_valid after %0d cycles", n);
        end else begin
            exp_rdv++;
            chk("rdv_latency", 32'(n), 32'(LAT + 1));
            chk("rdv_channel", 32'(rd_valid), 32'(1) << ch);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %h expected nothing", rd_data);
            end else begin
                chk("rd_data", rd_data, sb_q.pop_front());
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy %b after %0d cycles expected 0", busy, n);
        end
    endtask

    task automatic do_vec(input vec_t v);
        int n;
        @(negedge clk);
        clear_req();
        set_req(v.ch, v.wr, v.both | !v.wr, v.addr, v.size, v.din);
        sdram_dout32 = v.dout;
        if (!v.wr) sb_q.push_back(v.exp_rd);
        wait_cmd(n);
        chk("strobe", 32'({sdram_wr, sdram_rd, sdram_refresh}), v.wr ? 32'b100 : 32'b010);
        chk("ack", 32'(req_ack), 32'(1) << v.ch);
        chk("sdram_addr", 32'(sdram_addr), 32'(v.exp_addr));
        chk("wdm", 32'(sdram_wdm), 32'(v.exp_wdm));
        if (v.wr) chk("din32", sdram_din32, v.exp_din);
        clear_req();
        if (!v.wr) wait_rdv(v.ch);
        wait_idle();
    endtask

    initial begin
        int n;
        //          wr    both  ch addr        sz    din           dout          addr      din32         wdm      rd
        vecs[0] = '{1'b1, 1'b0, 0, 23'h000003, 2'd0, 32'h000000A5, 32'h0,        21'h0,     32'hA5A5A5A5, 4'b0111, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 0, 23'h000006, 2'd1, 32'h0,        32'h1234ABCD, 21'h1,     32'h0,        4'b0000, 32'h00001234};
        vecs[2] = '{1'b1, 1'b0, 1, 23'h000105, 2'd1, 32'h0000BEEF, 32'h0,        21'h41,    32'hBEEFBEEF, 4'b1100, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 0, 23'h7FFFFF, 2'd2, 32'hDEADBEEF, 32'h0,        21'h1FFFFF,32'hDEADBEEF, 4'b0000, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 1, 23'h000011, 2'd0, 32'h0,        32'h11223344, 21'h4,     32'h0,        4'b0000, 32'h00000033};
        vecs[5] = '{1'b0, 1'b0, 0, 23'h000022, 2'd2, 32'h0,        32'hCAFEF00D, 21'h8,     32'h0,        4'b0000, 32'hCAFEF00D};
        vecs[6] = '{1'b1, 1'b0, 1, 23'h000008, 2'd3, 32'h01020304, 32'h0,        21'h2,     32'h01020304, 4'b0000, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 1, 23'h000003, 2'd0, 32'h0,        32'h89ABCDEF, 21'h0,     32'h0,        4'b0000, 32'h00000089};
        vecs[8] = '{1'b1, 1'b1, 0, 23'h000010, 2'd2, 32'h55AA55AA, 32'h0,        21'h4,     32'h55AA55AA, 4'b0000, 32'h0};
        fv      = '{1'b0, 1'b0, 0, 23'h000100, 2'd2, 32'h0,        32'h13572468, 21'h40,    32'h0,        4'b0000, 32'h13572468};

        resetn = 1'b1;
        clear_req();
        req_addr = '0; req_size = '0; req_din = '0;
        refresh = 1'b0; sdram_busy = 1'b1; sdram_data_ready = 1'b1; sdram_dout32 = '0;
        #3 resetn = 1'b0;
        tick(2);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_fail", 32'(fail), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_strobes", 32'({sdram_wr, sdram_rd, sdram_refresh}), 32'd0);
        resetn = 1'b1;
        tick(3);
        chk("init_hold_busy", 32'(busy), 32'd1);
        sdram_busy = 1'b0;
        tick(2);
        chk("init_to_idle", 32'(busy), 32'd0);

        foreach (vecs[i]) do_vec(vecs[i]);
        tick(5);
        chk("rd_data_hold", rd_data, 32'h00000089);

        // Refresh pulse and ch1 read arrive together: refresh goes first.
        @(negedge clk);
        refresh = 1'b1;
        set_req(1, 1'b0, 1'b1, 23'h000040, 2'd2, 32'h0);
        sdram_dout32 = 32'h600DCAFE;
        sb_q.push_back(32'h600DCAFE);
        @(negedge clk);
        refresh = 1'b0;
        chk("refresh_first", 32'({sdram_wr, sdram_rd, sdram_refresh}), 32'b001);
        chk("refresh_no_ack", 32'(req_ack), 32'd0);
        wait_cmd(n);
        chk("after_ref_strobe", 32'({sdram_wr, sdram_rd, sdram_refresh}), 32'b010);
        chk("after_ref_ack", 32'(req_ack), 32'b10);
        chk("after_ref_addr", 32'(sdram_addr), 32'h10);
        chk("grant_spacing", 32'(n >= LAT + 1), 32'd1);
        clear_req();
        wait_rdv(1);
        wait_idle();

        // Sticky fail.
        chk("fail_clear", 32'(fail), 32'd0);
        sdram_data_ready = 1'b0;
        do_vec(fv);
        sdram_data_ready = 1'b1;
        chk("fail_set", 32'(fail), 32'd1);
        do_vec(vecs[0]);
        chk("fail_sticky", 32'(fail), 32'd1);
        @(negedge clk);
        resetn = 1'b0;
        tick(1);
        chk("fail_reset", 32'(fail), 32'd0);
        chk("rst2_rd_data", rd_data, 32'h0);
        chk("rst2_busy", 32'(busy), 32'd1);
        resetn = 1'b1;
        tick(2);
        chk("rst2_idle", 32'(busy), 32'd0);

        // Reset in the middle of a read: nothing may come back.
        @(negedge clk);
        set_req(1, 1'b0, 1'b1, 23'h000020, 2'd2, 32'h0);
        wait_cmd(n);
        clear_req();
        tick(2);
        resetn = 1'b0;
        tick(1);
        resetn = 1'b1;
        tick(15);
        chk("abort_no_rdv", 32'(n_rdv), 32'(exp_rdv));
        chk("abort_idle", 32'(busy), 32'd0);

        // Both channels hold reads: grants alternate starting at ch0.
        @(negedge clk);
        set_req(0, 1'b0, 1'b1, 23'h000100, 2'd2, 32'h0);
        set_req(1, 1'b0, 1'b1, 23'h000200, 2'd2, 32'h0);
        sdram_dout32 = 32'h0BADF00D;
        for (int i = 0; i < 4; i++) begin
            wait_cmd(n);
            chk("alt_strobe", 32'({sdram_wr, sdram_rd, sdram_refresh}), 32'b010);
            chk("alt_ack", 32'(req_ack), 32'(1) << (i % 2));
            chk("alt_addr", 32'(sdram_addr), (i % 2) ? 32'h80 : 32'h40);
            sb_q.push_back(32'h0BADF00D);
            if (i == 3) clear_req();
            wait_rdv(i % 2);
        end
        wait_idle();
        tick(5);
        chk("rdv_total", 32'(n_rdv), 32'(exp_rdv));
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
